// File: rtl/rect_overlay_wr_if.sv
// Box-in / DDR-burst-out bundle for the rectangle overlay writer.
// master: the tracker FIFO side plus the memory controller (drives boxes, data_req, finish).
// slave: the overlay writer (accepts boxes, issues write bursts). box_fill exists only with RECT_FILL_EN.
interface rect_overlay_wr_if #(
  parameter int COORD_W = 11,
  parameter int FRAME_W = 2,
  parameter int ADDR_W  = 27
);
  logic               frame_sync;
  logic               box_valid;
  logic               box_ready;
  logic [FRAME_W-1:0] box_frame;
  logic [COORD_W-1:0] box_x1;
  logic [COORD_W-1:0] box_y1;
  logic [COORD_W-1:0] box_x2;
  logic [COORD_W-1:0] box_y2;
  logic [15:0]        box_color;
`ifdef RECT_FILL_EN
  logic               box_fill;
`endif
  logic               box_drop;
  logic               busy;
  logic               wr_burst_req;
  logic [9:0]         wr_burst_len;
  logic [ADDR_W-1:0]  wr_burst_addr;
  logic [63:0]        wr_burst_data;
  logic               wr_burst_data_req;
  logic               burst_finish;

  modport master (
    output frame_sync, box_valid, box_frame, box_x1, box_y1, box_x2, box_y2, box_color,
`ifdef RECT_FILL_EN
    output box_fill,
`endif
    output wr_burst_data_req, burst_finish,
    input  box_ready, box_drop, busy, wr_burst_req, wr_burst_len, wr_burst_addr, wr_burst_data
  );

  modport slave (
    input  frame_sync, box_valid, box_frame, box_x1, box_y1, box_x2, box_y2, box_color,
`ifdef RECT_FILL_EN
    input  box_fill,
`endif
    input  wr_burst_data_req, burst_finish,
    output box_ready, box_drop, busy, wr_burst_req, wr_burst_len, wr_burst_addr, wr_burst_data
  );
endinterface

// File: rtl/rect_overlay_wr.sv
// Paints a tracker box outline (or solid box with RECT_FILL_EN) into a frame buffer as DDR write bursts.
// Latency: accept -> first wr_burst_req 2 cycles; burst_finish -> next req 2 cycles (same segment) / 3 (new segment).
// Backpressure: box_ready only in IDLE; each burst waits for burst_finish; frame_sync aborts after the current burst.
module rect_overlay_wr #(
  parameter int COORD_W   = 11,
  parameter int FRAME_W   = 2,
  parameter int PIX_SHIFT = 2,
  parameter int BURST_MAX = 128,
  parameter int THICK     = 2,
  parameter int ADDR_W    = 27
) (
  input logic              mem_clk,
  input logic              rst_n,
  rect_overlay_wr_if.slave bus
);

  localparam int WW = COORD_W - PIX_SHIFT;  // word-index width within a line
  localparam int RW = WW + 1;               // segment length in words, up to a full line
  localparam logic [COORD_W-1:0] T_M1  = COORD_W'(THICK - 1);
  localparam logic [COORD_W:0]   T2_M1 = (COORD_W + 1)'(2 * THICK - 1);

  typedef enum logic [2:0] {S_IDLE, S_SEG_START, S_REQ, S_BURST, S_BURST_END} state_t;

  state_t             r_state, w_next;
  logic [FRAME_W-1:0] r_frame;
  logic [COORD_W-1:0] r_x1, r_y1, r_x2, r_y2, r_line;
  logic [15:0]        r_color;
  logic               r_seg;      // 0: left edge (or full span), 1: right edge
  logic [ADDR_W-1:0]  r_addr;
  logic [RW-1:0]      r_remain;
  logic               r_req, r_drop, r_abort;

  logic               w_rdy, w_box_ok, w_acc, w_rej, w_abort, w_fill;
  logic [COORD_W-1:0] w_xspan, w_lend_x, w_rbeg_x, w_h;
  logic [WW-1:0]      w_wl, w_wr, w_lend, w_rbeg, w_sw, w_ew;
  logic               w_merge, w_short, w_top, w_bot, w_full, w_last_seg, w_last_row;
  logic [RW-1:0]      w_seg_len, w_rem_next;
  logic [ADDR_W-1:0]  w_seg_addr;
  logic [9:0]         w_len;

`ifdef RECT_FILL_EN
  logic r_fill;
  assign w_fill = r_fill;
`else
  assign w_fill = 1'b0;
`endif

  // Handshake: ready held low while reset is asserted, inverted boxes are consumed and dropped.
  assign w_rdy    = (r_state == S_IDLE) && rst_n;
  assign w_box_ok = (bus.box_x2 >= bus.box_x1) && (bus.box_y2 >= bus.box_y1);
  assign w_acc    = w_rdy && bus.box_valid && w_box_ok;
  assign w_rej    = w_rdy && bus.box_valid && !w_box_ok;
  assign w_abort  = r_abort || bus.frame_sync;

  // Edge extents clamp to the box so a narrow box never reads outside [x1,x2].
  assign w_xspan  = r_x2 - r_x1;
  assign w_lend_x = (w_xspan <= T_M1) ? r_x2 : r_x1 + T_M1;
  assign w_rbeg_x = (w_xspan <= T_M1) ? r_x1 : r_x2 - T_M1;
  assign w_wl     = r_x1[COORD_W-1:PIX_SHIFT];
  assign w_wr     = r_x2[COORD_W-1:PIX_SHIFT];
  assign w_lend   = w_lend_x[COORD_W-1:PIX_SHIFT];
  assign w_rbeg   = w_rbeg_x[COORD_W-1:PIX_SHIFT];

  // Row classification for the current line.
  assign w_h        = r_y2 - r_y1;
  assign w_short    = {1'b0, w_h} <= T2_M1;
  assign w_top      = (r_line - r_y1) <= T_M1;
  assign w_bot      = (r_y2 - r_line) <= T_M1;
  assign w_merge    = (RW'(w_lend) + RW'(1)) >= RW'(w_rbeg);
  assign w_full     = w_fill || w_short || w_top || w_bot || w_merge;
  assign w_last_seg = w_full || r_seg;
  assign w_last_row = (r_line == r_y2);

  // Segment bounds and start address for SEG_START.
  assign w_sw       = (w_full || !r_seg) ? w_wl : w_rbeg;
  assign w_ew       = (w_full ||  r_seg) ? w_wr : w_lend;
  assign w_seg_len  = RW'(w_ew) - RW'(w_sw) + RW'(1);
  assign w_seg_addr = ADDR_W'({r_frame, r_line, w_sw, 3'b000});
  assign w_rem_next = r_remain - RW'(w_len);

  // Burst length is the remaining segment words capped at BURST_MAX.
  always_comb begin
    w_len = 10'(r_remain);
    if (32'(r_remain) > BURST_MAX) w_len = 10'(BURST_MAX);
  end

  // Next-state logic; an abort is honoured only between bursts.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:      if (w_acc) w_next = S_SEG_START;
      S_SEG_START: w_next = w_abort ? S_IDLE : S_REQ;
      S_REQ:       w_next = S_BURST;
      S_BURST:     if (bus.burst_finish) w_next = S_BURST_END;
      S_BURST_END: begin
        if (w_abort)                      w_next = S_IDLE;
        else if (w_rem_next != '0)        w_next = S_REQ;
        else if (!w_last_seg)             w_next = S_SEG_START;
        else if (w_last_row)              w_next = S_IDLE;
        else                              w_next = S_SEG_START;
      end
      default:     w_next = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge mem_clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // Box latch, row/segment walk and burst address/length bookkeeping.
  always_ff @(posedge mem_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_frame <= '0; r_x1 <= '0; r_y1 <= '0; r_x2 <= '0; r_y2 <= '0;
      r_color <= '0; r_line <= '0; r_seg <= 1'b0; r_addr <= '0; r_remain <= '0;
`ifdef RECT_FILL_EN
      r_fill <= 1'b0;
`endif
    end else begin
      if (w_acc) begin
        r_frame <= bus.box_frame;
        r_x1    <= bus.box_x1;
        r_y1    <= bus.box_y1;
        r_x2    <= bus.box_x2;
        r_y2    <= bus.box_y2;
        r_color <= bus.box_color;
        r_line  <= bus.box_y1;
        r_seg   <= 1'b0;
`ifdef RECT_FILL_EN
        r_fill  <= bus.box_fill;
`endif
      end
      if (r_state == S_SEG_START && !w_abort) begin
        r_addr   <= w_seg_addr;
        r_remain <= w_seg_len;
      end
      if (r_state == S_BURST_END) begin
        r_addr   <= r_addr + ADDR_W'({w_len, 3'b000});
        r_remain <= w_abort ? '0 : w_rem_next;
        if (!w_abort && w_rem_next == '0) begin
          if (!w_last_seg) begin
            r_seg <= 1'b1;
          end else if (!w_last_row) begin
            r_line <= r_line + 1'b1;
            r_seg  <= 1'b0;
          end
        end
      end
    end
  end

  // Request strobe, drop pulse and abort flag.
  always_ff @(posedge mem_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_req   <= 1'b0;
      r_drop  <= 1'b0;
      r_abort <= 1'b0;
    end else begin
      r_drop <= w_rej;
      if (w_next == S_REQ)
        r_req <= 1'b1;
      else if ((r_state == S_REQ || r_state == S_BURST) && (bus.wr_burst_data_req || bus.burst_finish))
        r_req <= 1'b0;
      if (w_next == S_IDLE)
        r_abort <= 1'b0;
      else if (bus.frame_sync && r_state != S_IDLE)
        r_abort <= 1'b1;
    end
  end

  assign bus.box_ready     = w_rdy;
  assign bus.box_drop      = r_drop;
  assign bus.busy          = (r_state != S_IDLE);
  assign bus.wr_burst_req  = r_req;
  assign bus.wr_burst_len  = w_len;
  assign bus.wr_burst_addr = r_addr;
  assign bus.wr_burst_data = {4{r_color}};

endmodule
